wallace_mult_pipe: RTL and testbench

- Parametrised, pipelined Wallace-tree multiplier; next generation of the team's fixed 32-bit combinational Wallace multiplier.
- Accepts one WIDTH x WIDTH multiply per cycle through a valid/ready handshake.
- Supports per-operation signed or unsigned mode.
- Carries a user tag through the pipeline with each operation.
- Supports output backpressure. Sits between operand sources (ALU/DSP datapath) and a result consumer.

---
 rtl/wallace_mult_pipe.sv | 146 ++++++++++++++
 tb/tb_wallace_mult_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier with valid/ready handshake,
// per-operation signed/unsigned mode and a user tag carried with each result.
module wallace_mult_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic [TAG_W-1:0]   out_tag,
  output logic [2:0]         inflight
);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned NPP = WIDTH + 1;
  localparam int unsigned NL  = 16;

  logic [PW-1:0] pp [NPP];
  logic [PW-1:0] red_s;
  logic [PW-1:0] red_c;

  // Baugh-Wooley: in signed mode the mixed-sign AND terms are inverted and
  // the constant row 2^WIDTH + 2^(2*WIDTH-1) corrects the sum.
  always_comb begin : gen_pp
    logic [WIDTH-1:0] row;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      row = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
        row[j] = a[j] & b[i];
        if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) row[j] = ~row[j];
      end
      pp[i] = PW'(row) << i;
    end
    pp[WIDTH] = sgn ? ((PW'(1) << WIDTH) | (PW'(1) << (PW - 1))) : '0;
  end

  // Wallace layers: each group of three rows becomes a sum and a shifted
  // carry row through a rank of full adders; leftovers pass to the next layer.
  always_comb begin : wallace
    logic [PW-1:0] cur [NPP];
    logic [PW-1:0] nxt [NPP];
    int unsigned n;
    int unsigned m;
    int unsigned grp;
    cur = pp;
    nxt = '{default: '0};
    n   = NPP;
    m   = 0;
    grp = 0;
    for (int unsigned l = 0; l < NL; l++) begin
      if (n > 2) begin
        nxt = '{default: '0};
        m   = 0;
        grp = (n / 3) * 3;
        for (int unsigned r = 0; r + 2 < NPP; r += 3) begin
          if (r + 2 < n) begin
            nxt[m]     = cur[r] ^ cur[r+1] ^ cur[r+2];
            nxt[m + 1] = ((cur[r] & cur[r+1]) | (cur[r] & cur[r+2]) |
                          (cur[r+1] & cur[r+2])) << 1;
            m = m + 2;
          end
        end
        for (int unsigned r = 0; r < NPP; r++) begin
          if (r >= grp && r < n) begin
            nxt[m] = cur[r];
            m = m + 1;
          end
        end
        cur = nxt;
        n   = m;
      end
    end
    red_s = cur[0];
    red_c = cur[1];
  end

  logic             vld   [STAGES];
  logic [TAG_W-1:0] tag_r [STAGES];
  logic [PW-1:0]    sum_r [STAGES];
  logic [PW-1:0]    car_r [STAGES];
  logic             v_in  [STAGES];
  logic [TAG_W-1:0] t_in  [STAGES];
  logic [PW-1:0]    s_in  [STAGES];
  logic [PW-1:0]    c_in  [STAGES];
  logic             adv;

  assign adv      = !vld[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    v_in[0] = in_valid;
    t_in[0] = in_tag;
    s_in[0] = red_s;
    c_in[0] = red_c;
    for (int unsigned k = 1; k < STAGES; k++) begin
      v_in[k] = vld[k-1];
      t_in[k] = tag_r[k-1];
      s_in[k] = sum_r[k-1];
      c_in[k] = car_r[k-1];
    end
  end

  // Data registers load only behind a valid operation, so bubbles (and any
  // X on idle operand inputs) never reach prod.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld[k]   <= 1'b0;
        tag_r[k] <= '0;
        sum_r[k] <= '0;
        car_r[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld[k] <= v_in[k];
        if (v_in[k]) begin
          tag_r[k] <= t_in[k];
          if (k == STAGES - 1) begin
            sum_r[k] <= s_in[k] + c_in[k];
            car_r[k] <= '0;
          end else begin
            sum_r[k] <= s_in[k];
            car_r[k] <= c_in[k];
          end
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign prod      = sum_r[STAGES-1];
  assign out_tag   = tag_r[STAGES-1];

  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < STAGES; k++) inflight = inflight + 3'(vld[k]);
  end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: directed steps on a 32x32/3-stage instance and
// randomized sweeps on 8x8/1-stage and 16x16/4-stage instances.
module tb_wallace_mult_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid0, in_ready0, sgn0, out_valid0, out_ready0;
  logic [31:0] a0, b0;
  logic [3:0]  in_tag0, out_tag0;
  logic [63:0] prod0;
  logic [2:0]  inflight0;

  logic        in_valid1, in_ready1, sgn1, out_valid1, out_ready1;
  logic [7:0]  a1, b1;
  logic [3:0]  in_tag1, out_tag1;
  logic [15:0] prod1;
  logic [2:0]  inflight1;

  logic        in_valid2, in_ready2, sgn2, out_valid2, out_ready2;
  logic [15:0] a2, b2;
  logic [3:0]  in_tag2, out_tag2;
  logic [31:0] prod2;
  logic [2:0]  inflight2;

  wallace_mult_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .sgn(sgn0), .in_tag(in_tag0), .out_valid(out_valid0),
    .out_ready(out_ready0), .prod(prod0), .out_tag(out_tag0), .inflight(inflight0));
  wallace_mult_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sgn(sgn1), .in_tag(in_tag1), .out_valid(out_valid1),
    .out_ready(out_ready1), .prod(prod1), .out_tag(out_tag1), .inflight(inflight1));
  wallace_mult_pipe #(.WIDTH(16), .STAGES(4), .TAG_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sgn(sgn2), .in_tag(in_tag2), .out_valid(out_valid2),
    .out_ready(out_ready2), .prod(prod2), .out_tag(out_tag2), .inflight(inflight2));

  typedef struct packed {
    logic [3:0]   t;
    logic [127:0] p;
    int           cyc;
  } rec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  rec_t q [3][$];
  rec_t got0 [$];
  logic [127:0] last_p [3];
  bit   hold [3];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Exact product from plain integer arithmetic on sign/zero-extended operands.
  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                           input int unsigned w, input logic s);
    logic [127:0] lo, xe, ye;
    lo = (128'(1) << w) - 128'(1);
    xe = 128'(x) & lo;
    ye = 128'(y) & lo;
    if (s && x[w-1]) xe = xe | ~lo;
    if (s && y[w-1]) ye = ye | ~lo;
    return (xe * ye) & ((128'(1) << (2 * w)) - 128'(1));
  endfunction

  // Transaction-level scoreboard: ops are queued on input transfer and
  // retired in order on output transfer; inflight must equal queue depth.
  task automatic mon(input int unsigned d, input logic iv, input logic ir, input logic ov,
                     input logic ordy, input logic [127:0] p, input logic [3:0] t,
                     input logic [2:0] infl, input logic [127:0] pexp, input logic [3:0] tin);
    rec_t r;
    if (!rst_n) begin
      q[d].delete();
      hold[d] = 1'b0;
      return;
    end
    check($sformatf("d%0d inflight", d), 128'(infl), 128'(q[d].size()));
    if (hold[d]) check($sformatf("d%0d stall_hold", d), p, last_p[d]);
    if (q[d].size() == 0) check($sformatf("d%0d idle_valid", d), 128'(ov), 128'(0));
    if (ov && ordy && q[d].size() > 0) begin
      r = q[d].pop_front();
      check($sformatf("d%0d prod", d), p, r.p);
      check($sformatf("d%0d tag", d), 128'(t), 128'(r.t));
      if (d == 0) got0.push_back('{t: t, p: p, cyc: cyc_n});
    end
    hold[d]   = ov && !ordy;
    last_p[d] = p;
    if (iv && ir) q[d].push_back('{t: tin, p: pexp, cyc: cyc_n});
  endtask

  always @(negedge clk) mon(0, in_valid0, in_ready0, out_valid0, out_ready0, 128'(prod0),
                            out_tag0, inflight0, ref_mul(64'(a0), 64'(b0), 32, sgn0), in_tag0);
  always @(negedge clk) mon(1, in_valid1, in_ready1, out_valid1, out_ready1, 128'(prod1),
                            out_tag1, inflight1, ref_mul(64'(a1), 64'(b1), 8, sgn1), in_tag1);
  always @(negedge clk) mon(2, in_valid2, in_ready2, out_valid2, out_ready2, 128'(prod2),
                            out_tag2, inflight2, ref_mul(64'(a2), 64'(b2), 16, sgn2), in_tag2);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] t);
    in_valid0 = 1'b1; sgn0 = s; a0 = x; b0 = y; in_tag0 = t;
  endtask

  task automatic wait_got(input int n);
    for (int c = 0; c < 40 && got0.size() < n; c++) step();
  endtask

  int base, i, cnt, acc1, acc2, lat1, lat2;
  logic [63:0] exp64;

  initial begin
    rst_n = 1'b0;
    in_valid0 = 0; out_ready0 = 1; sgn0 = 0; a0 = '0; b0 = '0; in_tag0 = '0;
    in_valid1 = 0; out_ready1 = 1; sgn1 = 0; a1 = '0; b1 = '0; in_tag1 = '0;
    in_valid2 = 0; out_ready2 = 1; sgn2 = 0; a2 = '0; b2 = '0; in_tag2 = '0;
    step(); step();
    check("rst out_valid", 128'(out_valid0), 0);
    check("rst prod", 128'(prod0), 0);
    check("rst out_tag", 128'(out_tag0), 0);
    check("rst inflight", 128'(inflight0), 0);
    rst_n = 1'b1;
    step();
    check("rst in_ready", 128'(in_ready0), 1);

    // Single operation and latency
    drive0(0, 32'd19, 32'd15, 4'd1);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      cnt++;
      if (cnt == 1) in_valid0 = 1'b0;
      if (out_valid0) break;
    end
    check("single latency", 128'(cnt), 3);
    check("single prod", 128'(prod0), 285);
    check("single tag", 128'(out_tag0), 1);
    check("single inflight busy", 128'(inflight0), 1);
    step();
    check("single inflight done", 128'(inflight0), 0);
    check("single out_valid done", 128'(out_valid0), 0);

    // Unsigned corners back-to-back
    base = got0.size();
    drive0(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2); step();
    drive0(0, 32'h0, 32'hABCA_FFFF, 4'd3); step();
    drive0(0, 32'd9943000, 32'd3302367, 4'd4); step();
    in_valid0 = 1'b0;
    wait_got(base + 3);
    check("corner count", 128'(got0.size()), 128'(base + 3));
    if (got0.size() >= base + 3) begin
      exp64 = 64'd9943000 * 64'd3302367;
      check("corner ffff", got0[base].p, 128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001);
      check("corner zero", got0[base+1].p, 0);
      check("corner big", got0[base+2].p, 128'(exp64));
      check("corner tag order", 128'({got0[base].t, got0[base+1].t, got0[base+2].t}), 128'h234);
      check("corner consecutive a", 128'(got0[base+1].cyc - got0[base].cyc), 1);
      check("corner consecutive b", 128'(got0[base+2].cyc - got0[base+1].cyc), 1);
    end

    // Signed interleaved with unsigned
    base = got0.size();
    drive0(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5); step();
    drive0(1, 32'hFFFF_FFFE, 32'd3, 4'd6); step();
    drive0(1, 32'h8000_0000, 32'h8000_0000, 4'd7); step();
    drive0(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8); step();
    in_valid0 = 1'b0;
    wait_got(base + 4);
    check("signed count", 128'(got0.size()), 128'(base + 4));
    if (got0.size() >= base + 4) begin
      check("signed m1*m1", got0[base].p, 1);
      check("signed m2*3", got0[base+1].p, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFA);
      check("signed min*min", got0[base+2].p, 128'h0000_0000_0000_0000_4000_0000_0000_0000);
      check("unsigned after signed", got0[base+3].p, 128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001);
    end

    // Backpressure: out_ready low from the second cycle until the stall is checked
    base = got0.size();
    i = 0;
    for (int c = 0; c < 40 && i < 5; c++) begin
      out_ready0 = (c == 0 || c >= 8);
      drive0(0, 32'(1000 + i), 32'(7 * i + 3), 4'(8 + i));
      #2;
      if (c == 6) begin
        check("bp in_ready", 128'(in_ready0), 0);
        check("bp inflight", 128'(inflight0), 3);
        check("bp out_valid", 128'(out_valid0), 1);
        check("bp prod held", 128'(prod0), 3000);
        check("bp tag held", 128'(out_tag0), 8);
      end
      if (in_ready0) i++;
      step();
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    wait_got(base + 5);
    repeat (4) step();
    check("bp delivered", 128'(got0.size()), 128'(base + 5));
    for (int k = 0; k < 5; k++) begin
      if (base + k < got0.size()) begin
        check("bp prod", got0[base+k].p, 128'((1000 + k) * (7 * k + 3)));
        check("bp tag", 128'(got0[base+k].t), 128'(8 + k));
      end
    end

    // Asynchronous reset with two operations in flight
    base = got0.size();
    drive0(0, 32'd5, 32'd6, 4'd1); step();
    drive0(1, 32'hFFFF_FFF0, 32'd9, 4'd2); step();
    in_valid0 = 1'b0;
    check("mid inflight", 128'(inflight0), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", 128'(out_valid0), 0);
    check("mid rst prod", 128'(prod0), 0);
    check("mid rst inflight", 128'(inflight0), 0);
    step(); step();
    rst_n = 1'b1;
    repeat (10) step();
    check("mid no stale", 128'(got0.size()), 128'(base));

    // Latency of the sweep configurations
    in_valid1 = 1; a1 = 8'd200; b1 = 8'd3; sgn1 = 0; in_tag1 = 4'd9;
    in_valid2 = 1; a2 = 16'hFFFF; b2 = 16'd7; sgn2 = 1; in_tag2 = 4'd10;
    lat1 = 0; lat2 = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      in_valid1 = 0; in_valid2 = 0;
      if (out_valid1 && lat1 == 0) lat1 = c;
      if (out_valid2 && lat2 == 0) lat2 = c;
    end
    check("w8s1 latency", 128'(lat1), 1);
    check("w16s4 latency", 128'(lat2), 4);

    // Randomized sweep with random mode and backpressure
    acc1 = 0; acc2 = 0;
    for (int c = 0; c < 20000 && (acc1 < 2000 || acc2 < 2000); c++) begin
      in_valid1 = (acc1 < 2000) && ($urandom_range(0, 3) != 0);
      a1 = 8'($urandom); b1 = 8'($urandom); sgn1 = 1'($urandom); in_tag1 = 4'($urandom);
      out_ready1 = ($urandom_range(0, 3) != 0);
      in_valid2 = (acc2 < 2000) && ($urandom_range(0, 3) != 0);
      a2 = 16'($urandom); b2 = 16'($urandom); sgn2 = 1'($urandom); in_tag2 = 4'($urandom);
      out_ready2 = ($urandom_range(0, 3) != 0);
      #2;
      if (in_valid1 && in_ready1) acc1++;
      if (in_valid2 && in_ready2) acc2++;
      step();
    end
    in_valid1 = 0; in_valid2 = 0; out_ready1 = 1; out_ready2 = 1;
    for (int c = 0; c < 50 && (q[1].size() != 0 || q[2].size() != 0); c++) step();
    step();
    check("w8 accepted", 128'(acc1), 2000);
    check("w16 accepted", 128'(acc2), 2000);
    check("w8 drained", 128'(q[1].size()), 0);
    check("w16 drained", 128'(q[2].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
